// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Fixed-latency HI/LO multiply/divide unit with kill and mthi/mtlo.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] c_mult_cnt = 6'(MULT_LAT - 1);
    localparam logic [5:0] c_div_cnt  = 6'(DIV_LAT - 1);

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [1:0]         r_op;      // {is_div, is_unsigned} of the latched op
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_uquot;
    logic [WIDTH-1:0]   w_urem;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Sign-extending to 2*WIDTH makes the truncated product the signed product.
    always_comb begin
        w_ext_a = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
        w_ext_b = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
        w_prod  = w_ext_a * w_ext_b;
    end

    // Signed divide on magnitudes; most-negative / -1 falls out as most-negative.
    always_comb begin
        w_neg_a = ~r_op[0] & r_a[WIDTH-1];
        w_neg_b = ~r_op[0] & r_b[WIDTH-1];
        w_abs_a = w_neg_a ? (~r_a + 1'b1) : r_a;
        w_abs_b = w_neg_b ? (~r_b + 1'b1) : r_b;
        w_uquot = '0;
        w_urem  = '0;
        if (r_b != '0) begin
            w_uquot = w_abs_a / w_abs_b;
            w_urem  = w_abs_a % w_abs_b;
        end
        w_quot  = (w_neg_a ^ w_neg_b) ? (~w_uquot + 1'b1) : w_uquot;
        w_rem   = w_neg_a ? (~w_urem + 1'b1) : w_urem;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !kill) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_op    <= op[1:0];
                                r_a     <= a;
                                r_b     <= b;
                                r_cnt   <= op[1] ? c_div_cnt : c_mult_cnt;
                                r_state <= S_RUN;
                            end
                            3'b100:  r_hi <= a;
                            3'b101:  r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        if (!r_op[1]) begin
                            {r_hi, r_lo} <= w_prod;
                        end else if (r_b != '0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign stall_req = start | busy;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Vector table, corner sequences and random ops vs. arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int WIDTH    = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int TIMEOUT  = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    mult_div_unit #(
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t        tbl[11];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the shadow HI/LO pair.
    task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output int lat);
        longint          sa, sb;
        longint unsigned p;
        lat = 0;
        case (mop)
            3'd0: begin
                sa = longint'($signed(ma)); sb = longint'($signed(mb));
                p  = longint'(sa * sb);
                {m_hi, m_lo} = p;
                lat = MULT_LAT;
            end
            3'd1: begin
                p = {32'b0, ma} * {32'b0, mb};
                {m_hi, m_lo} = p;
                lat = MULT_LAT;
            end
            3'd2: begin
                lat = DIV_LAT;
                if (mb != 0) begin
                    sa = longint'($signed(ma)); sb = longint'($signed(mb));
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            3'd3: begin
                lat = DIV_LAT;
                if (mb != 0) begin
                    m_lo = ma / mb;
                    m_hi = ma % mb;
                end
            end
            3'd4: m_hi = ma;
            3'd5: m_lo = ma;
            default: ;
        endcase
    endtask

    // Issue one op, scramble the operand bus, count busy cycles.
    task automatic exec(input logic [2:0] xop, input logic [31:0] xa, input logic [31:0] xb,
                        output int n);
        @(negedge clk);
        start = 1'b1; op = xop; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 0;
        while (busy && n < TIMEOUT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] xop, input logic [31:0] xa,
                          input logic [31:0] xb);
        int n, lat;
        exec(xop, xa, xb, n);
        model(xop, xa, xb, lat);
        chk({name, " latency"}, 32'(n), 32'(lat));
        chk({name, " hi"}, hi, m_hi);
        chk({name, " lo"}, lo, m_lo);
    endtask

    initial begin
        int          n, lat;
        logic        stall_ok;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MULT_LAT};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MULT_LAT};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        tbl[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        tbl[4]  = '{3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 0};
        tbl[5]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hCAFEF00D, 0};
        tbl[6]  = '{3'd6, 32'h00000001, 32'h00000001, 32'h12345678, 32'hCAFEF00D, 0};
        tbl[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        tbl[8]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, DIV_LAT};
        tbl[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
        tbl[10] = '{3'd0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MULT_LAT};

        reset = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset stall_req", 32'(stall_req), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            exec(tbl[i].op, tbl[i].a, tbl[i].b, n);
            chk($sformatf("vec%0d latency", i), 32'(n), 32'(tbl[i].lat));
            chk($sformatf("vec%0d hi", i), hi, tbl[i].hi);
            chk($sformatf("vec%0d lo", i), lo, tbl[i].lo);
            model(tbl[i].op, tbl[i].a, tbl[i].b, lat);
        end

        // mthi plus new operands presented while a mult is running
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        chk("mthi-in-run busy", 32'(busy), 32'h1);
        op = 3'd4; a = 32'hDEADBEEF; b = 32'h55;
        n = 0;
        while (busy && n < TIMEOUT) begin
            n++;
            @(negedge clk);
            start = 1'b0;
        end
        model(3'd0, 32'd3, 32'd4, lat);
        chk("mthi-in-run latency", 32'(n), 32'(MULT_LAT));
        chk("mthi-in-run hi", hi, m_hi);
        chk("mthi-in-run lo", lo, m_lo);

        // kill on cycle 3 of a mult
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'hFFFF; b = 32'hFFFF;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); kill = 1'b1;
        @(negedge clk); kill = 1'b0;
        chk("kill3 busy", 32'(busy), 32'h0);
        repeat (8) @(negedge clk);
        chk("kill3 hi", hi, m_hi);
        chk("kill3 lo", lo, m_lo);

        // kill in the final RUN cycle
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
        @(negedge clk); start = 1'b0;
        repeat (MULT_LAT - 1) @(negedge clk);
        chk("killlast busy", 32'(busy), 32'h1);
        kill = 1'b1;
        @(negedge clk); kill = 1'b0;
        chk("killlast busy after", 32'(busy), 32'h0);
        chk("killlast hi", hi, m_hi);
        chk("killlast lo", lo, m_lo);

        // kill and start together in IDLE
        @(negedge clk); start = 1'b1; kill = 1'b1; op = 3'd4; a = 32'h11111111;
        @(negedge clk); start = 1'b0; kill = 1'b0;
        chk("killstart busy", 32'(busy), 32'h0);
        chk("killstart hi", hi, m_hi);

        // reset in the middle of a div
        run_op("pre-reset mthi", 3'd4, 32'h0000ABCD, 32'h0);
        @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        m_hi = '0; m_lo = '0;
        chk("midreset busy", 32'(busy), 32'h0);
        chk("midreset hi", hi, 32'h0);
        chk("midreset lo", lo, 32'h0);
        repeat (DIV_LAT + 2) @(negedge clk);
        chk("midreset late hi", hi, 32'h0);
        chk("midreset late lo", lo, 32'h0);
        run_op("post-reset divu", 3'd3, 32'd100, 32'd3);

        // back-to-back mult then multu with start held
        stall_ok = 1'b1;
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'hFFFFFFFE; b = 32'd3;
        @(negedge clk);
        chk("b2b first busy", 32'(busy), 32'h1);
        op = 3'd1;
        n = 0;
        while (busy && n < TIMEOUT) begin
            if (!stall_req) stall_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        model(3'd0, 32'hFFFFFFFE, 32'd3, lat);
        chk("b2b first latency", 32'(n), 32'(lat));
        chk("b2b first hi", hi, m_hi);
        chk("b2b first lo", lo, m_lo);
        if (!stall_req) stall_ok = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("b2b second accepted", 32'(busy), 32'h1);
        n = 0;
        while (busy && n < TIMEOUT) begin
            if (!stall_req) stall_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        model(3'd1, 32'hFFFFFFFE, 32'd3, lat);
        chk("b2b second latency", 32'(n), 32'(lat));
        chk("b2b second hi", hi, m_hi);
        chk("b2b second lo", lo, m_lo);
        chk("b2b stall_req held", 32'(stall_ok), 32'h1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
